// File: rtl/bram_octa_loader.sv
// Stream loader for the octa diffusion engine: demuxes PS words into score/subgraph banks,
// zero-fills the score-sum banks, then raises rdy_flag to open the diffusion clock gate.
module bram_octa_loader #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int LOAD_DEPTH = 8192,
  parameter int SUM_DEPTH  = 4096,
  parameter int PARALLEL   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic [ADDR_WIDTH-1:0] ld_addr,
  output logic [DATA_WIDTH-1:0] ld_data,
  output logic [PARALLEL-1:0]   ld_we_s,
  output logic [PARALLEL-1:0]   ld_we_g,
  output logic [ADDR_WIDTH-1:0] sum_addr,
  output logic [PARALLEL-1:0]   sum_we,
  output logic                  rdy_flag,
  output logic                  err
);

  localparam int BANKS = 2 * PARALLEL;
  localparam int BW    = $clog2(BANKS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] LOAD_LAST = ADDR_WIDTH'(LOAD_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] SUM_LAST  = ADDR_WIDTH'(SUM_DEPTH - 1);
  localparam logic [BW-1:0]         BANK_LAST = BW'(BANKS - 1);
  localparam logic [BW-1:0]         PAR_B     = BW'(PARALLEL);

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_addr_cnt;
  logic [BW-1:0]         r_bank_idx;
  logic [ADDR_WIDTH-1:0] r_ld_addr;
  logic [DATA_WIDTH-1:0] r_ld_data;
  logic [PARALLEL-1:0]   r_ld_we_s;
  logic [PARALLEL-1:0]   r_ld_we_g;
  logic [ADDR_WIDTH-1:0] r_sum_addr;
  logic [PARALLEL-1:0]   r_sum_we;
  logic                  r_rdy;
  logic                  r_err;

  logic                  w_final;
  logic [PARALLEL-1:0]   w_we_s;
  logic [PARALLEL-1:0]   w_we_g;

  assign w_final = (r_addr_cnt == LOAD_LAST) && (r_bank_idx == BANK_LAST);

  // First half of bank_idx selects a score bank, second half a subgraph bank.
  always_comb begin
    w_we_s = '0;
    w_we_g = '0;
    if (r_bank_idx < PAR_B) w_we_s = PARALLEL'(1) << r_bank_idx;
    else                    w_we_g = PARALLEL'(1) << (r_bank_idx - PAR_B);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_addr_cnt <= '0;
      r_bank_idx <= '0;
      r_ld_addr  <= '0;
      r_ld_data  <= '0;
      r_ld_we_s  <= '0;
      r_ld_we_g  <= '0;
      r_sum_addr <= '0;
      r_sum_we   <= '0;
      r_rdy      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_ld_we_s <= '0;
      r_ld_we_g <= '0;
      r_sum_we  <= '0;
      if (abort) begin
        r_state <= S_IDLE;
        r_rdy   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_state    <= S_LOAD;
              r_addr_cnt <= '0;
              r_bank_idx <= '0;
              r_err      <= 1'b0;
            end
          end
          S_LOAD: begin
            if (s_valid) begin
              r_ld_addr <= r_addr_cnt;
              r_ld_data <= s_data;
              r_ld_we_s <= w_we_s;
              r_ld_we_g <= w_we_g;
              if (s_last != w_final) r_err <= 1'b1;
              // Counters stop on the final word so addr_cnt never passes LOAD_DEPTH-1.
              if (w_final) begin
                r_state <= S_CLEAR;
              end else if (r_bank_idx == BANK_LAST) begin
                r_bank_idx <= '0;
                r_addr_cnt <= r_addr_cnt + 1'b1;
              end else begin
                r_bank_idx <= r_bank_idx + 1'b1;
              end
            end
          end
          S_CLEAR: begin
            // sum_we is low on entry, so the first CLEAR cycle restarts the address at 0.
            if (r_sum_we[0] && (r_sum_addr == SUM_LAST)) begin
              r_state <= S_DONE;
            end else begin
              r_sum_we   <= '1;
              r_sum_addr <= r_sum_we[0] ? r_sum_addr + 1'b1 : '0;
            end
          end
          S_DONE: begin
            if (start) begin
              r_state    <= S_LOAD;
              r_addr_cnt <= '0;
              r_bank_idx <= '0;
              r_err      <= 1'b0;
              r_rdy      <= 1'b0;
            end else begin
              r_rdy <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign s_ready  = (r_state == S_LOAD);
  assign ld_addr  = r_ld_addr;
  assign ld_data  = r_ld_data;
  assign ld_we_s  = r_ld_we_s;
  assign ld_we_g  = r_ld_we_g;
  assign sum_addr = r_sum_addr;
  assign sum_we   = r_sum_we;
  assign rdy_flag = r_rdy;
  assign err      = r_err;

endmodule
